// File: rtl/if_prefetch_stage_if.sv
// Bundle of pipeline-control, instruction-memory and IF/ID signals of the fetch stage.
// Latency: none (wires only).
// Backpressure: carried by hold_id (ID side) and the req/ready pair (memory side).
//
// master : fetch stage side (drives mem_req/mem_addr and the IF/ID outputs)
// slave  : environment side (pipeline control, instruction memory, ID stage)
interface if_prefetch_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    // pipeline control
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic              if_flush;
    logic              hold_id;
    // instruction memory port
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    // IF/ID register and queue status
    logic [ADDR_W-1:0] id_pc;
    logic [DATA_W-1:0] id_instr;
    logic              id_valid;
    logic [LVL_W-1:0]  fifo_level;

    modport master (
        input  redirect, redirect_target, if_flush, hold_id, mem_rdata, mem_ready,
        output mem_req, mem_addr, id_pc, id_instr, id_valid, fifo_level
    );

    modport slave (
        output redirect, redirect_target, if_flush, hold_id, mem_rdata, mem_ready,
        input  mem_req, mem_addr, id_pc, id_instr, id_valid, fifo_level
    );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction fetch with a DEPTH-entry prefetch queue decoupling memory reads from ID stalls.
// Latency: mem_ready sampled at edge N queues the word at N; it reaches IF/ID at N+1 (no bypass).
// Backpressure: hold_id freezes IF/ID and stops pops; new reads are only issued while a slot is free.
//
// Ports: clk (rising edge), rst (async, active-high), bus = master side of if_prefetch_stage_if:
//   redirect/redirect_target, if_flush, hold_id in; mem_req/mem_addr out, mem_rdata/mem_ready in;
//   id_pc (fetch PC + 4), id_instr, id_valid, fifo_level out.
module if_prefetch_stage #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h5400_0000)
) (
    input  logic clk,
    input  logic rst,
    if_prefetch_stage_if.master bus
);
    localparam int unsigned      LVL_W   = $clog2(DEPTH + 1);
    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // may issue a read when a queue slot is free
        ST_WAIT = 2'd1,   // read outstanding, data will be queued
        ST_DROP = 2'd2    // read outstanding but cancelled by a redirect
    } state_t;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_n;
    logic              mem_req_q, mem_req_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic              push;

    // queue storage and bookkeeping
    logic [ADDR_W-1:0] q_pc4   [DEPTH];
    logic [DATA_W-1:0] q_instr [DEPTH];
    logic              q_vld   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              pop;

    // IF/ID register
    logic [ADDR_W-1:0] id_pc_q;
    logic [DATA_W-1:0] id_instr_q;
    logic              id_valid_q;

    // ---------------------------------------------------------------- fetch FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_n;
            fetch_pc_q <= fetch_pc_n;
            mem_req_q  <= mem_req_n;
            mem_addr_q <= mem_addr_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        fetch_pc_n = fetch_pc_q;
        mem_req_n  = 1'b0;
        mem_addr_n = mem_addr_q;   // address stays put until the next request
        push       = 1'b0;

        case (state_q)
            ST_REQ: begin
                // The level test uses the current occupancy, so a granted slot can
                // only grow (pops, flushes) before the data arrives: no overflow.
                if (bus.redirect) begin
                    fetch_pc_n = bus.redirect_target;
                end else if (level_q < DEPTH_L) begin
                    mem_req_n  = 1'b1;
                    mem_addr_n = fetch_pc_q;
                    state_n    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.redirect) begin
                    fetch_pc_n = bus.redirect_target;
                    // data arriving together with the redirect is simply not queued
                    state_n    = bus.mem_ready ? ST_REQ : ST_DROP;
                end else if (bus.mem_ready) begin
                    push       = 1'b1;
                    fetch_pc_n = fetch_pc_q + ADDR_W'(4);
                    state_n    = ST_REQ;
                end
            end
            ST_DROP: begin
                if (bus.redirect) begin
                    fetch_pc_n = bus.redirect_target;
                end
                // the cancelled read completes here; a coincident redirect has
                // already updated fetch_pc, so nothing else is outstanding
                if (bus.mem_ready) begin
                    state_n = ST_REQ;
                end
            end
            default: begin
                state_n = ST_REQ;
            end
        endcase
    end

    // ---------------------------------------------------------------- prefetch queue
    // A redirect empties the queue and blocks the pop in the same edge.
    assign pop = !bus.redirect && !bus.if_flush && !bus.hold_id && (level_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc4[wr_ptr_q]   <= fetch_pc_q + ADDR_W'(4);
            // an all-zero word is replaced by a NOP and marked as not-from-memory
            q_instr[wr_ptr_q] <= (bus.mem_rdata == '0) ? NOP_INSTR : bus.mem_rdata;
            q_vld[wr_ptr_q]   <= (bus.mem_rdata != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (bus.redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // ---------------------------------------------------------------- IF/ID register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end else if (bus.if_flush) begin
            // flush wins over hold; the PC is left as is
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end else if (bus.hold_id) begin
            id_pc_q    <= id_pc_q;
        end else if (pop) begin
            id_pc_q    <= q_pc4[rd_ptr_q];
            id_instr_q <= q_instr[rd_ptr_q];
            id_valid_q <= q_vld[rd_ptr_q];
        end else begin
            // nothing usable (empty queue or redirect edge): bubble
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.id_pc      = id_pc_q;
    assign bus.id_instr   = id_instr_q;
    assign bus.id_valid   = id_valid_q;
    assign bus.fifo_level = level_q;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed scenarios plus a randomized run against a stream model.
// Latency: memory answers each request after a configurable number of cycles.
// Backpressure: hold_id / if_flush / redirect driven per scenario or randomly.
`timescale 1ns/1ps
module tb_if_prefetch_stage;
    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] NOP    = 32'h5400_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_prefetch_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    if_prefetch_stage #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .RESET_PC(32'h0), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // memory model state
    bit          pending;
    int          cnt;
    logic [31:0] req_a;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] zero_addr = 32'hFFFF_FFF0;
    int          cyc = 0;
    int          last_rdy_cyc = -10;
    int          overlap_cnt = 0;

    // what happened at the most recent edge
    bit          ld_vld;
    logic [31:0] ld_pc, ld_instr;
    bit          req_seen;
    logic [31:0] req_addr;
    bit          redir_seen;
    logic [31:0] redir_tgt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == zero_addr) return 32'h0;
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return (w == 32'h0) ? NOP : w;
    endfunction

    // Advance one edge, record what the DUT did, then play the memory for the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.mem_ready === 1'b1 && !rst) last_rdy_cyc = cyc;
        ld_vld     = (bus.id_valid === 1'b1) && !bus.hold_id && !bus.if_flush && !bus.redirect && !rst;
        ld_pc      = bus.id_pc;
        ld_instr   = bus.id_instr;
        redir_seen = bus.redirect && !rst;
        redir_tgt  = bus.redirect_target;
        req_seen   = (bus.mem_req === 1'b1);
        req_addr   = bus.mem_addr;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
        if (req_seen) begin
            if (pending) overlap_cnt++;
            pending = 1'b1;
            cnt     = $urandom_range(lat_max, lat_min);
            req_a   = req_addr;
        end
        if (pending) begin
            cnt--;
            if (cnt == 0) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem_word(req_a);
                pending       = 1'b0;
            end
        end
    endtask

    task automatic drive_idle();
        bus.redirect        = 1'b0;
        bus.redirect_target = '0;
        bus.if_flush        = 1'b0;
        bus.hold_id         = 1'b0;
        bus.mem_ready       = 1'b0;
        bus.mem_rdata       = '0;
    endtask

    task automatic apply_reset();
        drive_idle();
        pending = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        #1 rst = 1'b1;
        #1;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%h exp=0", bus.mem_req); end
        total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
        total++; if (bus.fifo_level !== 3'd0) begin bad++; $display("FAIL rst_fifo_level got=%h exp=0", bus.fifo_level); end
        total++; if (bus.id_pc !== 32'h0) begin bad++; $display("FAIL rst_id_pc got=%h exp=0", bus.id_pc); end
        total++; if (bus.id_instr !== NOP) begin bad++; $display("FAIL rst_id_instr got=%h exp=%h", bus.id_instr, NOP); end
        total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid got=%h exp=0", bus.id_valid); end
        @(posedge clk);
        #1;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_hold_mem_req got=%h exp=0", bus.mem_req); end
        rst = 1'b0;
    endtask

    task automatic test_seq_fetch();
        int nreq, nld;
        lat_min = 2; lat_max = 2;
        apply_reset();
        tick();
        total++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
            bad++; $display("FAIL t1_first_req req=%h addr=%h exp req=1 addr=0", bus.mem_req, bus.mem_addr);
        end
        nreq = 1; nld = 0;
        for (int i = 0; i < 60 && (nreq < 4 || nld < 4); i++) begin
            tick();
            if (req_seen && nreq < 4) begin
                total++; if (req_addr !== 32'(4 * nreq)) begin bad++; $display("FAIL t1_req_addr got=%h exp=%h", req_addr, 32'(4 * nreq)); end
                nreq++;
            end
            if (ld_vld && nld < 4) begin
                total++; if (ld_pc !== 32'(4 * (nld + 1))) begin bad++; $display("FAIL t1_id_pc got=%h exp=%h", ld_pc, 32'(4 * (nld + 1))); end
                total++; if (ld_instr !== exp_instr(32'(4 * nld))) begin bad++; $display("FAIL t1_id_instr got=%h exp=%h", ld_instr, exp_instr(32'(4 * nld))); end
                total++; if (cyc != last_rdy_cyc + 1) begin bad++; $display("FAIL t1_latency got=%0d exp=%0d", cyc - last_rdy_cyc, 1); end
                nld++;
            end
        end
        total++; if (nreq != 4 || nld != 4) begin bad++; $display("FAIL t1_timeout reqs=%0d loads=%0d exp 4/4", nreq, nld); end
    endtask

    task automatic test_hold_fill();
        int nreq, nld;
        bit got_req;
        logic [31:0] first_req;
        lat_min = 1; lat_max = 1;
        apply_reset();
        bus.hold_id = 1'b1;
        nreq = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (req_seen) nreq++;
        end
        total++; if (nreq != DEPTH) begin bad++; $display("FAIL t2_reads got=%0d exp=%0d", nreq, DEPTH); end
        total++; if (bus.fifo_level !== 3'd4) begin bad++; $display("FAIL t2_level got=%0d exp=4", bus.fifo_level); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL t2_req_idle got=%h exp=0", bus.mem_req); end
        total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL t2_id_held got=%h exp=0", bus.id_valid); end
        bus.hold_id = 1'b0;
        nld = 0; got_req = 1'b0; first_req = '0;
        for (int i = 0; i < 30 && (nld < 4 || !got_req); i++) begin
            tick();
            if (req_seen && !got_req) begin got_req = 1'b1; first_req = req_addr; end
            if (ld_vld && nld < 4) begin
                total++; if (ld_pc !== 32'(4 * (nld + 1))) begin bad++; $display("FAIL t2_drain_pc got=%h exp=%h", ld_pc, 32'(4 * (nld + 1))); end
                total++; if (ld_instr !== exp_instr(32'(4 * nld))) begin bad++; $display("FAIL t2_drain_instr got=%h exp=%h", ld_instr, exp_instr(32'(4 * nld))); end
                nld++;
            end
        end
        total++; if (!got_req || first_req !== 32'h10) begin bad++; $display("FAIL t2_resume seen=%0d addr=%h exp addr=10", got_req, first_req); end
        total++; if (nld != 4) begin bad++; $display("FAIL t2_drain_count got=%0d exp=4", nld); end
    endtask

    task automatic test_redirect_wait();
        bit found, got_req, got_ld;
        lat_min = 4; lat_max = 4;
        apply_reset();
        bus.hold_id = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (req_seen && req_addr == 32'h8) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL t3_wait8_timeout got=0 exp=1"); end
        total++; if (bus.fifo_level !== 3'd2) begin bad++; $display("FAIL t3_level_pre got=%0d exp=2", bus.fifo_level); end
        bus.redirect = 1'b1; bus.redirect_target = 32'h100;
        tick();
        bus.redirect = 1'b0;
        total++; if (bus.fifo_level !== 3'd0) begin bad++; $display("FAIL t3_flush_level got=%0d exp=0", bus.fifo_level); end
        bus.hold_id = 1'b0;
        got_req = 1'b0; got_ld = 1'b0;
        for (int i = 0; i < 50 && !(got_req && got_ld); i++) begin
            tick();
            if (req_seen && !got_req) begin
                got_req = 1'b1;
                total++; if (req_addr !== 32'h100) begin bad++; $display("FAIL t3_new_addr got=%h exp=100", req_addr); end
            end
            if (ld_vld && !got_ld) begin
                got_ld = 1'b1;
                total++; if (ld_pc !== 32'h104) begin bad++; $display("FAIL t3_id_pc got=%h exp=104", ld_pc); end
                total++; if (ld_instr !== exp_instr(32'h100)) begin bad++; $display("FAIL t3_id_instr got=%h exp=%h", ld_instr, exp_instr(32'h100)); end
            end
        end
        total++; if (!(got_req && got_ld)) begin bad++; $display("FAIL t3_timeout req=%0d ld=%0d exp 1/1", got_req, got_ld); end
    endtask

    task automatic test_redirect_ready_flush();
        bit found, got_ld;
        logic [31:0] pc_keep;
        lat_min = 3; lat_max = 3;
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.mem_ready === 1'b1) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL t4_ready_timeout got=0 exp=1"); end
        bus.redirect = 1'b1; bus.redirect_target = 32'h200;
        tick();
        bus.redirect = 1'b0;
        total++; if (bus.fifo_level !== 3'd0) begin bad++; $display("FAIL t4_discard_level got=%0d exp=0", bus.fifo_level); end
        tick();
        total++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin
            bad++; $display("FAIL t4_restart req=%h addr=%h exp req=1 addr=200", bus.mem_req, bus.mem_addr);
        end
        got_ld = 1'b0;
        for (int i = 0; i < 30 && !got_ld; i++) begin
            tick();
            if (ld_vld) begin
                got_ld = 1'b1;
                total++; if (ld_pc !== 32'h204) begin bad++; $display("FAIL t4_id_pc got=%h exp=204", ld_pc); end
            end
        end
        total++; if (!got_ld) begin bad++; $display("FAIL t4_load_timeout got=0 exp=1"); end
        pc_keep = bus.id_pc;
        bus.hold_id = 1'b1; bus.if_flush = 1'b1;
        tick();
        bus.if_flush = 1'b0;
        total++; if (bus.id_instr !== NOP) begin bad++; $display("FAIL t4_flush_instr got=%h exp=%h", bus.id_instr, NOP); end
        total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL t4_flush_valid got=%h exp=0", bus.id_valid); end
        total++; if (bus.id_pc !== pc_keep) begin bad++; $display("FAIL t4_flush_pc got=%h exp=%h", bus.id_pc, pc_keep); end
        tick();
        total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL t4_hold_after_flush got=%h exp=0", bus.id_valid); end
        bus.hold_id = 1'b0;
    endtask

    task automatic test_zero_word();
        bit found, got_ld;
        lat_min = 1; lat_max = 1;
        zero_addr = 32'h10;
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (bus.id_pc === 32'h14) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL t5_pc14_timeout got=0 exp=1"); end
        total++; if (bus.id_instr !== NOP) begin bad++; $display("FAIL t5_instr got=%h exp=%h", bus.id_instr, NOP); end
        total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL t5_valid got=%h exp=0", bus.id_valid); end
        got_ld = 1'b0;
        for (int i = 0; i < 30 && !got_ld; i++) begin
            tick();
            if (ld_vld) begin
                got_ld = 1'b1;
                total++; if (ld_pc !== 32'h18 || ld_instr !== exp_instr(32'h14)) begin
                    bad++; $display("FAIL t5_next pc=%h instr=%h exp pc=18 instr=%h", ld_pc, ld_instr, exp_instr(32'h14));
                end
            end
        end
        total++; if (!got_ld) begin bad++; $display("FAIL t5_next_timeout got=0 exp=1"); end
        zero_addr = 32'hFFFF_FFF0;
    endtask

    task automatic test_reset_midread();
        bit found, got_ld;
        lat_min = 3; lat_max = 3;
        apply_reset();
        bus.hold_id = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (req_seen && bus.fifo_level === 3'd3) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL t6_setup_timeout got=0 exp=1"); end
        #2 rst = 1'b1;
        #1;
        pending = 1'b0;
        total++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.fifo_level !== 3'd0) begin
            bad++; $display("FAIL t6_async_mem req=%h addr=%h level=%0d exp 0/0/0", bus.mem_req, bus.mem_addr, bus.fifo_level);
        end
        total++;
        if (bus.id_pc !== 32'h0 || bus.id_instr !== NOP || bus.id_valid !== 1'b0) begin
            bad++; $display("FAIL t6_async_id pc=%h instr=%h valid=%h exp 0/%h/0", bus.id_pc, bus.id_instr, bus.id_valid, NOP);
        end
        tick();
        rst = 1'b0;
        bus.hold_id   = 1'b0;
        bus.mem_ready = 1'b1;          // dangling completion of the forgotten read
        bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        total++;
        if (req_seen !== 1'b1 || req_addr !== 32'h0 || bus.fifo_level !== 3'd0) begin
            bad++; $display("FAIL t6_restart req=%0d addr=%h level=%0d exp 1/0/0", req_seen, req_addr, bus.fifo_level);
        end
        got_ld = 1'b0;
        for (int i = 0; i < 30 && !got_ld; i++) begin
            tick();
            if (ld_vld) begin
                got_ld = 1'b1;
                total++; if (ld_pc !== 32'h4 || ld_instr !== exp_instr(32'h0)) begin
                    bad++; $display("FAIL t6_first_load pc=%h instr=%h exp pc=4 instr=%h", ld_pc, ld_instr, exp_instr(32'h0));
                end
            end
        end
        total++; if (!got_ld) begin bad++; $display("FAIL t6_load_timeout got=0 exp=1"); end
    endtask

    // Stream model: loaded instructions form a contiguous PC sequence restarting at
    // target+4 after each redirect; requests walk by 4 and restart at the target.
    task automatic test_random();
        logic [31:0] exp_req, exp_next;
        int nld;
        lat_min = 1; lat_max = 4;
        apply_reset();
        overlap_cnt = 0;
        exp_req = 32'h0; exp_next = 32'h4; nld = 0;
        for (int i = 0; i < 1500; i++) begin
            bus.hold_id  = ($urandom_range(9, 0) < 3);
            bus.if_flush = ($urandom_range(9, 0) == 0);
            bus.redirect = ($urandom_range(24, 0) == 0);
            if ($urandom_range(3, 0) == 0) bus.redirect_target = 32'hFFFF_FFF8;
            else                           bus.redirect_target = 32'($urandom_range(1023, 0)) << 2;
            tick();
            if (ld_vld) begin
                nld++;
                total++; if (ld_pc !== exp_next) begin bad++; $display("FAIL rnd_pc got=%h exp=%h", ld_pc, exp_next); end
                total++; if (ld_instr !== exp_instr(ld_pc - 32'h4)) begin bad++; $display("FAIL rnd_instr got=%h exp=%h", ld_instr, exp_instr(ld_pc - 32'h4)); end
                exp_next = ld_pc + 32'h4;
            end
            if (req_seen) begin
                total++; if (req_addr !== exp_req) begin bad++; $display("FAIL rnd_req_addr got=%h exp=%h", req_addr, exp_req); end
                exp_req = req_addr + 32'h4;
            end
            if (redir_seen) begin
                exp_req  = redir_tgt;
                exp_next = redir_tgt + 32'h4;
            end
            total++; if (bus.fifo_level > 3'd4) begin bad++; $display("FAIL rnd_level got=%0d exp<=4", bus.fifo_level); end
        end
        drive_idle();
        total++; if (overlap_cnt != 0) begin bad++; $display("FAIL rnd_outstanding got=%0d exp=0", overlap_cnt); end
        total++; if (nld < 100) begin bad++; $display("FAIL rnd_progress got=%0d exp>=100", nld); end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_hold_fill();
        test_redirect_wait();
        test_redirect_ready_flush();
        test_zero_word();
        test_reset_midread();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
